mig_truth_table_gen: RTL and testbench

//  Programmable majority-inverter-graph (MIG) evaluator for N-input functions. It holds a netlist of
//  NUM_NODES 3-input majority nodes in registers and sweeps all 2^NUM_IN input assignments, one per

---
 rtl/mig_pkg.sv | 35 +++
 rtl/mig_truth_table_gen_node_eval.sv | 34 +++
 rtl/mig_truth_table_gen.sv | 172 +++++++++++++++++
 tb/tb_mig_truth_table_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mig_pkg.sv
// Shared types, constants and the fanin legality rule
// for the MIG truth-table generator.
package mig_pkg;

  localparam int NUM_IN    = 7;
  localparam int NUM_NODES = 6;
  localparam int SELW      = $clog2(1 + NUM_IN + NUM_NODES);
  localparam int NODEW     = $clog2(NUM_NODES + 1);

  localparam logic [SELW-1:0] SEL_CONST0  = '0;
  localparam logic [SELW-1:0] SEL_IN_BASE = SELW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  typedef struct packed {
    logic [SELW-1:0] sel_a;
    logic [SELW-1:0] sel_b;
    logic [SELW-1:0] sel_c;
    logic [2:0]      inv;
  } node_cfg_t;

  // Node k sees const 0, inputs and nodes below k only;
  // node index NUM_NODES is the output select.
  function automatic logic sel_is_legal(
    input int              node,
    input logic [SELW-1:0] sel
  );
    return int'(sel) <= NUM_IN + node;
  endfunction

endpackage

// File: rtl/mig_truth_table_gen_node_eval.sv
// One 3-input majority node over the prefix of the
// signal vector it may legally reference.
module mig_node_eval
  import mig_pkg::*;
#(
  parameter int IDX = 0,
  parameter int W   = NUM_IN + 1
) (
  input  logic [W-1:0] sig_i,
  input  node_cfg_t    cfg_i,
  output logic         out_o
);

  function automatic logic pick(
    input logic [W-1:0]    s,
    input logic [SELW-1:0] sel
  );
    logic v;
    v = 1'b0;
    for (int i = 0; i < W; i++)
      if (int'(sel) == i) v = s[i];
    if (!sel_is_legal(IDX, sel)) v = 1'b0;
    return v;
  endfunction

  logic a, b, c;

  assign a = pick(sig_i, cfg_i.sel_a) ^ cfg_i.inv[0];
  assign b = pick(sig_i, cfg_i.sel_b) ^ cfg_i.inv[1];
  assign c = pick(sig_i, cfg_i.sel_c) ^ cfg_i.inv[2];

  assign out_o = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/mig_truth_table_gen.sv
// Programmable MIG evaluator sweeping all input assignments.
// MIG_COMPL_EN enables fanin/output complement (full MIG).
module mig_truth_table_gen
  import mig_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [NODEW-1:0]     cfg_node,
  input  logic [SELW-1:0]      cfg_sel_a,
  input  logic [SELW-1:0]      cfg_sel_b,
  input  logic [SELW-1:0]      cfg_sel_c,
  input  logic [2:0]           cfg_inv,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [2**NUM_IN-1:0] tt_out
);

  localparam int TTW   = 2**NUM_IN;
  localparam int FULLW = 1 + NUM_IN + NUM_NODES;

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] cnt_q, cnt_d;
  logic [TTW-1:0]    tt_q, tt_d;
  logic              err_q;

  logic [SELW-1:0] sa_q [NUM_NODES];
  logic [SELW-1:0] sb_q [NUM_NODES];
  logic [SELW-1:0] sc_q [NUM_NODES];
  logic [SELW-1:0] out_sel_q;
  logic            out_inv;
  node_cfg_t       ncfg [NUM_NODES];

  logic wr_node, wr_out, wr_legal, f;
  logic [FULLW-1:0] full;

  assign busy    = (state_q == SWEEP);
  assign done    = (state_q == DONE);
  assign cfg_err = err_q;
  assign tt_out  = tt_q;

  assign wr_node = cfg_we && !busy
                && int'(cfg_node) < NUM_NODES;
  assign wr_out  = cfg_we && !busy
                && int'(cfg_node) == NUM_NODES;

  always_comb begin
    wr_legal = sel_is_legal(int'(cfg_node), cfg_sel_a);
    if (int'(cfg_node) < NUM_NODES)
      wr_legal = wr_legal
              && sel_is_legal(int'(cfg_node), cfg_sel_b)
              && sel_is_legal(int'(cfg_node), cfg_sel_c);
  end

`ifdef MIG_COMPL_EN
  logic [2:0] inv_q [NUM_NODES];
  logic       out_inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NODES; i++) inv_q[i] <= '0;
      out_inv_q <= 1'b0;
    end else begin
      if (wr_node) inv_q[cfg_node] <= cfg_inv;
      if (wr_out)  out_inv_q <= cfg_inv[0];
    end
  end

  assign out_inv = out_inv_q;

  always_comb
    for (int i = 0; i < NUM_NODES; i++)
      ncfg[i] = '{sa_q[i], sb_q[i], sc_q[i], inv_q[i]};
`else
  logic unused_inv;
  assign unused_inv = ^cfg_inv;
  assign out_inv    = 1'b0;

  always_comb
    for (int i = 0; i < NUM_NODES; i++)
      ncfg[i] = '{sa_q[i], sb_q[i], sc_q[i], 3'b000};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        sa_q[i] <= SEL_CONST0;
        sb_q[i] <= SEL_CONST0;
        sc_q[i] <= SEL_CONST0;
      end
      out_sel_q <= SEL_CONST0;
      err_q     <= 1'b0;
    end else begin
      if (wr_node) begin
        sa_q[cfg_node] <= cfg_sel_a;
        sb_q[cfg_node] <= cfg_sel_b;
        sc_q[cfg_node] <= cfg_sel_c;
      end
      if (wr_out) out_sel_q <= cfg_sel_a;
      if ((wr_node || wr_out) && !wr_legal) err_q <= 1'b1;
    end
  end

  // Each stage appends its output to a private copy of the
  // vector so the node chain has no combinational loop.
  for (genvar k = 0; k < NUM_NODES; k++) begin : g_node
    logic [NUM_IN+k:0]   fin;
    logic [NUM_IN+k+1:0] v;
    logic                o;

    if (k == 0) begin : g_first
      assign fin = {cnt_q, 1'b0};
    end else begin : g_rest
      assign fin = g_node[k-1].v;
    end

    mig_node_eval #(
      .IDX (k),
      .W   (NUM_IN + k + 1)
    ) u_eval (
      .sig_i (fin),
      .cfg_i (ncfg[k]),
      .out_o (o)
    );

    assign v = {o, fin};
  end

  assign full = g_node[NUM_NODES-1].v;

  always_comb begin
    f = 1'b0;
    for (int i = 0; i < FULLW; i++)
      if (int'(out_sel_q) == i) f = full[i];
    f = f ^ out_inv;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SWEEP;
        cnt_d   = '0;
        tt_d    = '0;
      end
      SWEEP: begin
        tt_d[cnt_q] = f;
        cnt_d       = cnt_q + 1'b1;
        if (&cnt_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
    end
  end

endmodule

// File: tb/tb_mig_truth_table_gen.sv
// Directed bench for mig_truth_table_gen with a
// truth-table scoreboard checked on each done pulse.
module tb_mig_truth_table_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [2:0]   cfg_node;
  logic [3:0]   cfg_sel_a, cfg_sel_b, cfg_sel_c;
  logic [2:0]   cfg_inv;
  logic         start;
  logic         busy, done, cfg_err;
  logic [127:0] tt_out;

  int errs   = 0;
  int checks = 0;

  logic [127:0] sb_q [$];

  localparam logic [127:0] C2 =
    128'hfee8eae8ece8e888eee8e8c8e8a8e880;

  mig_truth_table_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_node  (cfg_node),
    .cfg_sel_a (cfg_sel_a),
    .cfg_sel_b (cfg_sel_b),
    .cfg_sel_c (cfg_sel_c),
    .cfg_inv   (cfg_inv),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .tt_out    (tt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input int node, input int a,
                    input int b, input int c,
                    input logic [2:0] iv);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_node  = 3'(node);
    cfg_sel_a = 4'(a);
    cfg_sel_b = 4'(b);
    cfg_sel_c = 4'(c);
    cfg_inv   = iv;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Called at a negedge; start is seen at the next posedge.
  task automatic sweep(input string tag,
                       input logic [127:0] exp,
                       input bit glitch,
                       input bit wr_start);
    int n;
    int nd;
    logic [127:0] e;
    sb_q.push_back(exp);
    start = 1'b1;
    if (wr_start) begin
      cfg_we    = 1'b1;
      cfg_node  = 3'd6;
      cfg_sel_a = 4'd13;
      cfg_inv   = 3'b000;
    end
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      if (n == 2) chk({tag, "_busy"}, busy, 1);
      if (glitch && n == 10) begin
        cfg_we    = 1'b1;
        cfg_node  = 3'd0;
        cfg_sel_a = 4'd11;
      end
      if (glitch && n == 11) cfg_we = 1'b0;
      if (glitch && n == 50) start = 1'b1;
      if (glitch && n == 51) start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 129);
    e = sb_q.pop_front();
    chk({tag, "_tt"}, tt_out, e);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {done, busy}, 2'b00);
    if (glitch) begin
      nd = 0;
      repeat (140) begin
        @(negedge clk);
        if (done) nd++;
      end
      chk({tag, "_single_done"}, nd, 0);
    end
  endtask

  task automatic program_c2();
    wr(0, 1, 5, 7, 3'b000);
    wr(1, 2, 6, 8, 3'b000);
    wr(2, 1, 2, 3, 3'b000);
    wr(3, 2, 3, 5, 3'b000);
    wr(4, 1, 4, 11, 3'b000);
    wr(5, 9, 10, 12, 3'b000);
    wr(6, 13, 0, 0, 3'b000);
  endtask

  initial begin
    logic [127:0] e4;
    logic [6:0]   jj;
    int           nd;

    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_node  = '0;
    cfg_sel_a = '0;
    cfg_sel_b = '0;
    cfg_sel_c = '0;
    cfg_inv   = '0;
    start     = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_state",
        {busy, done, cfg_err, tt_out}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep("default", '0, 0, 0);
    chk("default_err", cfg_err, 0);

    program_c2();
    chk("c2_err", cfg_err, 0);
    sweep("c2", C2, 0, 0);

    wr(6, 13, 0, 0, 3'b001);
`ifdef MIG_COMPL_EN
    sweep("out_inv", ~C2, 0, 0);
`else
    sweep("out_inv", C2, 0, 0);
`endif

    // Out select restored in the same cycle as start.
    sweep("wr_with_start", C2, 0, 1);

    sweep("busy_glitch", C2, 1, 0);
    chk("busy_wr_no_err", cfg_err, 0);
    sweep("cfg_kept", C2, 0, 0);

    wr(0, 11, 5, 7, 3'b000);
    chk("fwd_err", cfg_err, 1);
    wr(6, 8, 0, 0, 3'b000);
    for (int j = 0; j < 128; j++) begin
      jj = 7'(j);
      e4[j] = jj[4] & jj[6];
    end
    sweep("fwd_eval", e4, 0, 0);
    chk("fwd_err_sticky", cfg_err, 1);

    program_c2();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    chk("mid_tt_nonzero", tt_out != '0, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_state",
        {busy, done, cfg_err, tt_out}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (140) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort_no_done", nd, 0);
    sweep("after_abort", '0, 0, 0);
    program_c2();
    sweep("after_abort_c2", C2, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
